// File: rtl/decode_lane_cfg_ctrl_pkg.sv
// Shared types and constants for the fetch/decode lane reconfiguration sequencer.
package decode_lane_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    LDC_IDLE,
    LDC_HOLD,
    LDC_FLUSH,
    LDC_APPLY,
    LDC_ACK
  } ldc_state_t;

  localparam int LDC_QUIET_CYCLES = 2;
  localparam int LDC_FETCH_WIDTH  = 4;

  typedef logic [LDC_FETCH_WIDTH-1:0] lane_mask_t;

endpackage

// File: rtl/decode_lane_cfg_ctrl_drain.sv
// Drain monitor: counts consecutive quiet cycles and total HOLD cycles so the
// sequencer knows when the pipe has emptied or the drain has taken too long.
module ldc_drain_monitor
  import decode_lane_cfg_ctrl_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic quiet,
  output logic drained,
  output logic timeout
);

  localparam int              TO_W       = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX     = TO_W'(DRAIN_TIMEOUT);
  localparam logic [1:0]      QUIET_LAST = 2'(LDC_QUIET_CYCLES - 1);

  logic [1:0]      quiet_cnt;
  logic [TO_W-1:0] to_cnt;

  // Both counters saturate so a stalled sequencer can never wrap them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_cnt <= '0;
      to_cnt    <= '0;
    end else if (clear) begin
      quiet_cnt <= '0;
      to_cnt    <= '0;
    end else if (enable) begin
      if (quiet) begin
        if (quiet_cnt != 2'b11) quiet_cnt <= quiet_cnt + 2'd1;
      end else begin
        quiet_cnt <= '0;
      end
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // The current cycle counts toward the quiet run, so the decision is made
  // in the cycle that completes the run rather than one cycle later.
  assign drained = quiet && (quiet_cnt >= QUIET_LAST);
  assign timeout = (to_cnt >= TO_LAST);

endmodule

// File: rtl/decode_lane_cfg_ctrl.sv
// Lane reconfiguration sequencer: drains Fetch2Decode/Decode, flushes, then
// swaps the active fetch lane mask atomically; also merges decode flush/stall.
module decode_lane_cfg_ctrl
  import decode_lane_cfg_ctrl_pkg::*;
#(
  parameter int                     FETCH_WIDTH     = LDC_FETCH_WIDTH,
  parameter logic [FETCH_WIDTH-1:0] RESET_LANE_MASK = '1,
  parameter int                     DRAIN_TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfgReq_i,
  input  logic [FETCH_WIDTH-1:0] cfgLaneMask_i,
  output logic                   cfgAck_o,
  output logic                   cfgErr_o,
  output logic                   busy_o,
  input  logic                   fs2Ready_i,
  input  logic                   decodeReady_i,
  input  logic                   instBufferFull_i,
  input  logic                   recoverFlag_i,
  input  logic                   exceptionFlag_i,
  input  logic                   resetFetch_i,
  output logic                   fetchHold_o,
  output logic                   decFlush_o,
  output logic                   decStall_o,
  output logic [FETCH_WIDTH-1:0] fetchLaneActive_o
);

  // An all-zero request would leave fetch with no lanes; lane 0 stays on.
  function automatic logic [FETCH_WIDTH-1:0] force_lane0(input logic [FETCH_WIDTH-1:0] m);
    return (m == '0) ? FETCH_WIDTH'(1) : m;
  endfunction

  ldc_state_t             state;
  ldc_state_t             state_next;
  logic [FETCH_WIDTH-1:0] pend_mask;
  logic [FETCH_WIDTH-1:0] lane_mask;
  logic [FETCH_WIDTH-1:0] req_mask;
  logic                   cfg_err;
  logic                   capture;
  logic                   apply;
  logic                   mon_clear;
  logic                   mon_en;
  logic                   err_set;
  logic                   err_clr;
  logic                   ext_flush;
  logic                   quiet;
  logic                   drained;
  logic                   timeout;

  assign req_mask  = force_lane0(cfgLaneMask_i);
  assign ext_flush = recoverFlag_i | exceptionFlag_i | resetFetch_i;
  assign quiet     = !fs2Ready_i && !decodeReady_i;

  ldc_drain_monitor #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain (
    .clk    (clk),
    .reset  (reset),
    .clear  (mon_clear),
    .enable (mon_en),
    .quiet  (quiet),
    .drained(drained),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LDC_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    apply      = 1'b0;
    mon_clear  = 1'b0;
    mon_en     = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state)
      LDC_IDLE: begin
        // External flushes here are deliberately ignored: the request still proceeds.
        if (cfgReq_i) begin
          capture = 1'b1;
          if (req_mask == lane_mask) begin
            state_next = LDC_ACK;
          end else begin
            state_next = LDC_HOLD;
            err_clr    = 1'b1;
            mon_clear  = 1'b1;
          end
        end
      end
      LDC_HOLD: begin
        mon_en = 1'b1;
        if (drained || ext_flush || timeout) begin
          state_next = LDC_FLUSH;
          err_set    = timeout;
        end
      end
      LDC_FLUSH: state_next = LDC_APPLY;
      LDC_APPLY: begin
        apply      = 1'b1;
        state_next = LDC_ACK;
      end
      LDC_ACK: begin
        if (!cfgReq_i) state_next = LDC_IDLE;
      end
      default: state_next = LDC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_mask <= RESET_LANE_MASK;
      lane_mask <= RESET_LANE_MASK;
      cfg_err   <= 1'b0;
    end else begin
      if (capture) pend_mask <= req_mask;
      if (apply)   lane_mask <= pend_mask;
      if (err_clr)      cfg_err <= 1'b0;
      else if (err_set) cfg_err <= 1'b1;
    end
  end

  assign fetchLaneActive_o = lane_mask;
  assign cfgErr_o          = cfg_err;
  assign cfgAck_o          = (state == LDC_ACK);
  assign busy_o            = (state != LDC_IDLE);
  assign fetchHold_o       = (state == LDC_HOLD) || (state == LDC_FLUSH) || (state == LDC_APPLY);
  assign decFlush_o        = ext_flush || (state == LDC_FLUSH);
  assign decStall_o        = instBufferFull_i || (state == LDC_APPLY);

endmodule
